// File: rtl/spi_xfer_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared spi_topmodule master.
// slave: seen from the arbiter; master: seen from requesters and the SPI master.
interface spi_xfer_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_mode;
  logic [32*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [31:0]          spi_control;
  logic [31:0]          spi_datain;
  logic [31:0]          spi_dataout;
  logic [31:0]          spi_status;

  modport slave (
    input  req_valid, req_mode, req_wdata, spi_dataout, spi_status,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, spi_control, spi_datain
  );

  modport master (
    output req_valid, req_mode, req_wdata, spi_dataout, spi_status,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, spi_control, spi_datain
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters; runs one
// 32-bit transfer per grant and returns the MISO word (or a timeout error).
module spi_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rstn,
  spi_xfer_arbiter_if.slave bus
);

  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int unsigned NR = NREQ;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_BUSY, S_DONE, S_ERR
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_last;
  logic [1:0]      r_mode;
  logic            r_en;
  logic [31:0]     r_datain;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [NREQ-1:0] r_req_ready;
  logic [NREQ-1:0] r_rsp_valid;

  logic            w_any;
  logic [IDW-1:0]  w_gid;
  logic [1:0]      w_mode;
  logic [31:0]     w_wdata;
  int unsigned     w_idx;
  logic            w_gap_done;
  logic            w_tmo;

  // Scan from the requester after the last winner, wrapping; first hit wins.
  always_comb begin
    w_any   = 1'b0;
    w_gid   = r_last;
    w_mode  = '0;
    w_wdata = '0;
    w_idx   = 0;
    for (int unsigned i = 1; i <= NR; i++) begin
      w_idx = (32'(r_last) + i) % NR;
      if (!w_any && 1'(bus.req_valid >> w_idx)) begin
        w_any   = 1'b1;
        w_gid   = IDW'(w_idx);
        w_mode  = 2'(bus.req_mode >> (2 * w_idx));
        w_wdata = 32'(bus.req_wdata >> (32 * w_idx));
      end
    end
  end

  assign w_gap_done = (r_timer == TW'(GAP - 1));
  assign w_tmo      = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_id        <= '0;
      r_last      <= IDW'(NREQ - 1);
      r_mode      <= '0;
      r_en        <= 1'b0;
      r_datain    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      if (r_timer != '1) r_timer <= r_timer + TW'(1);
      // Outputs are set on the transition edge so they are valid throughout the new state.
      case (r_state)
        S_IDLE: begin
          r_en <= 1'b0;
          if (w_any) begin
            r_id        <= w_gid;
            r_mode      <= w_mode;
            r_datain    <= w_wdata;
            r_req_ready <= NREQ'(1) << w_gid;
            r_state     <= S_SETUP;
            r_timer     <= '0;
          end
        end
        S_SETUP: begin
          if (w_gap_done) begin
            r_en    <= 1'b1;
            r_state <= S_START;
            r_timer <= '0;
          end
        end
        S_START, S_BUSY: begin
          if (r_state == S_START && bus.spi_status[0]) begin
            r_state <= S_BUSY;
            r_timer <= '0;
          end else if (r_state == S_BUSY && !bus.spi_status[0]) begin
            r_en        <= 1'b0;
            r_rdata     <= bus.spi_dataout;
            r_err       <= 1'b0;
            r_rsp_valid <= NREQ'(1) << r_id;
            r_last      <= r_id;
            r_state     <= S_DONE;
            r_timer     <= '0;
          end else if (w_tmo) begin
            r_en        <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b1;
            r_rsp_valid <= NREQ'(1) << r_id;
            r_last      <= r_id;
            r_state     <= S_ERR;
            r_timer     <= '0;
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_timer <= '0;
        end
        default: begin
          r_en    <= 1'b0;
          r_state <= S_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_err     = r_err;
  assign bus.spi_control = {29'b0, r_mode, r_en};
  assign bus.spi_datain  = r_datain;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a behavioural model of the SPI master.
module tb_spi_xfer_arbiter;
  localparam int NREQ    = 4;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 256;
  localparam int BUSYC   = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_xfer_arbiter_if #(.NREQ(NREQ)) bus();

  spi_xfer_arbiter #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // SPI master model: busy for BUSYC cycles after an enable rise, aborts if enable drops.
  logic        m_busy   = 1'b0;
  logic        m_enq    = 1'b0;
  logic        m_dead   = 1'b0;
  int          m_cnt    = 0;
  logic [31:0] m_dout   = '0;
  logic [31:0] m_miso   = '0;
  logic [31:0] m_rx     = '0;
  logic [1:0]  m_rxmode = '0;

  always @(posedge clk) begin
    m_enq <= bus.spi_control[0];
    if (!m_busy) begin
      if (bus.spi_control[0] && !m_enq && !m_dead) begin
        m_busy   <= 1'b1;
        m_cnt    <= 0;
        m_rx     <= bus.spi_datain;
        m_rxmode <= bus.spi_control[2:1];
      end
    end else if (!bus.spi_control[0]) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == BUSYC - 1) begin
        m_busy <= 1'b0;
        m_dout <= m_miso;
      end
    end
  end

  assign bus.spi_status  = {31'b0, m_busy};
  assign bus.spi_dataout = m_dout;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output logic [3:0] rdy, output int n);
    rdy = '0;
    n   = 0;
    while (n < budget) begin
      tick();
      n++;
      if (bus.req_ready != '0) begin
        rdy = bus.req_ready;
        break;
      end
    end
  endtask

  task automatic wait_en(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (bus.spi_control[0]) break;
    end
  endtask

  task automatic wait_rsp(input int budget, output logic [3:0] v, output logic [31:0] d,
                          output logic e, output logic [31:0] c, output int n);
    v = '0; d = '0; e = 1'b0; c = '0;
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (bus.rsp_valid != '0) begin
        v = bus.rsp_valid;
        d = bus.rsp_rdata;
        e = bus.rsp_err;
        c = bus.spi_control;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ready=%b valid=%b err=%b want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err);
    end
    n_tests++;
    if ({bus.rsp_rdata, bus.spi_control, bus.spi_datain} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_words: got rdata=%h ctrl=%h datain=%h want 0",
               bus.rsp_rdata, bus.spi_control, bus.spi_datain);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single;
    logic [3:0] rdy, v;
    logic [31:0] d, c;
    logic e;
    int n;
    m_miso = 32'h88885678;
    bus.req_mode = '0;
    bus.req_wdata[31:0] = 32'h87654321;
    bus.req_valid = 4'b0001;
    wait_ready(20, rdy, n);
    bus.req_valid = '0;
    n_tests++;
    if (rdy !== 4'b0001) begin
      n_fail++; $display("FAIL t1_ready: got %b want 0001", rdy);
    end
    n_tests++;
    if (bus.spi_control !== 32'h0 || bus.spi_datain !== 32'h87654321) begin
      n_fail++; $display("FAIL t1_setup: got ctrl=%h datain=%h want 0 87654321",
                         bus.spi_control, bus.spi_datain);
    end
    wait_en(20, n);
    n_tests++;
    if (n !== GAP) begin
      n_fail++; $display("FAIL t1_start_latency: got %0d want %0d", n, GAP);
    end
    wait_rsp(500, v, d, e, c, n);
    n_tests++;
    if (v !== 4'b0001 || d !== 32'h88885678 || e !== 1'b0 || c[0] !== 1'b0) begin
      n_fail++; $display("FAIL t1_rsp: got v=%b d=%h e=%b en=%b want 0001 88885678 0 0",
                         v, d, e, c[0]);
    end
    n_tests++;
    if (n !== BUSYC + 2) begin
      n_fail++; $display("FAIL t1_rsp_latency: got %0d want %0d", n, BUSYC + 2);
    end
    n_tests++;
    if (m_rx !== 32'h87654321) begin
      n_fail++; $display("FAIL t1_mosi: got %h want 87654321", m_rx);
    end
    tick();
    n_tests++;
    if (bus.rsp_valid !== 4'b0 || bus.rsp_rdata !== 32'h88885678) begin
      n_fail++; $display("FAIL t1_pulse_hold: got v=%b d=%h want 0000 88885678",
                         bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] rdy, v;
    logic [31:0] d, c;
    logic e;
    int n;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_miso = 32'h0badcafe;
    bus.req_wdata = {32'h33330003, 32'h22220002, 32'h11110001, 32'h00000000};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready(400, rdy, n);
      n_tests++;
      if (rdy !== exp_g[k]) begin
        n_fail++; $display("FAIL t2_order%0d: got %b want %b", k, rdy, exp_g[k]);
      end
      if (k > 0) begin
        n_tests++;
        if (!(n >= GAP + 2)) begin
          n_fail++; $display("FAIL t2_gap%0d: got %0d want >= %0d", k, n, GAP + 2);
        end
      end
    end
    bus.req_valid = '0;
    wait_rsp(400, v, d, e, c, n);
    n_tests++;
    if (v !== 4'b0001 || d !== 32'h0badcafe || m_rx !== 32'h00000000) begin
      n_fail++; $display("FAIL t2_last_rsp: got v=%b d=%h rx=%h want 0001 0badcafe 00000000",
                         v, d, m_rx);
    end
  endtask

  task automatic test_modes;
    logic [3:0] rdy, v;
    logic [31:0] d, c;
    logic e;
    int n;
    int          ids  [2] = '{1, 2};
    logic [1:0]  md   [2] = '{2'b01, 2'b10};
    logic [31:0] wd   [2] = '{32'hfedcba98, 32'hba984321};
    logic [31:0] mi   [2] = '{32'h13572468, 32'h2468ace0};
    logic [3:0]  oh;
    for (int k = 0; k < 2; k++) begin
      oh = 4'b0001 << ids[k];
      m_miso = mi[k];
      bus.req_mode[2*ids[k] +: 2]   = md[k];
      bus.req_wdata[32*ids[k] +: 32] = wd[k];
      bus.req_valid = oh;
      wait_ready(20, rdy, n);
      bus.req_valid = '0;
      n_tests++;
      if (rdy !== oh) begin
        n_fail++; $display("FAIL t3_ready%0d: got %b want %b", k, rdy, oh);
      end
      n_tests++;
      if (bus.spi_control[2:0] !== {md[k], 1'b0}) begin
        n_fail++; $display("FAIL t3_mode_settle%0d: got %b want %b",
                           k, bus.spi_control[2:0], {md[k], 1'b0});
      end
      wait_en(20, n);
      n_tests++;
      if (n !== GAP) begin
        n_fail++; $display("FAIL t3_gap%0d: got %0d want %0d", k, n, GAP);
      end
      wait_rsp(500, v, d, e, c, n);
      n_tests++;
      if (v !== oh || d !== mi[k] || e !== 1'b0 || c[2:0] !== {md[k], 1'b0}) begin
        n_fail++; $display("FAIL t3_rsp%0d: got v=%b d=%h e=%b ctrl=%b want %b %h 0 %b",
                           k, v, d, e, c[2:0], oh, mi[k], {md[k], 1'b0});
      end
      n_tests++;
      if (m_rx !== wd[k] || m_rxmode !== md[k]) begin
        n_fail++; $display("FAIL t3_slave%0d: got rx=%h mode=%b want %h %b",
                           k, m_rx, m_rxmode, wd[k], md[k]);
      end
    end
  endtask

  task automatic test_timeout;
    logic [3:0] rdy, v;
    logic [31:0] d, c;
    logic e;
    int n;
    m_dead = 1'b1;
    bus.req_mode[1:0]   = 2'b00;
    bus.req_wdata[31:0] = 32'h55aa55aa;
    bus.req_valid = 4'b0001;
    wait_ready(20, rdy, n);
    bus.req_valid = '0;
    n_tests++;
    if (rdy !== 4'b0001 || bus.rsp_rdata !== 32'h2468ace0) begin
      n_fail++; $display("FAIL t4_ready_hold: got rdy=%b rdata=%h want 0001 2468ace0",
                         rdy, bus.rsp_rdata);
    end
    wait_rsp(TIMEOUT + 100, v, d, e, c, n);
    n_tests++;
    if (v !== 4'b0001 || d !== 32'h0 || e !== 1'b1 || c[0] !== 1'b0) begin
      n_fail++; $display("FAIL t4_err_rsp: got v=%b d=%h e=%b en=%b want 0001 0 1 0",
                         v, d, e, c[0]);
    end
    n_tests++;
    if (n !== GAP + TIMEOUT) begin
      n_fail++; $display("FAIL t4_latency: got %0d want %0d", n, GAP + TIMEOUT);
    end
    m_dead = 1'b0;
    tick();
    n_tests++;
    if (bus.rsp_valid !== 4'b0) begin
      n_fail++; $display("FAIL t4_pulse: got %b want 0000", bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [3:0] rdy, v;
    logic [31:0] d, c;
    logic e;
    int n, bad;
    logic hit;
    m_miso = 32'hdeadbeef;
    bus.req_wdata[127:96] = 32'h0f0f0f0f;
    bus.req_valid = 4'b1000;
    wait_ready(20, rdy, n);
    bus.req_valid = '0;
    n_tests++;
    if (rdy !== 4'b1000) begin
      n_fail++; $display("FAIL t5_ready: got %b want 1000", rdy);
    end
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      tick();
      if (m_busy && m_cnt == 32) hit = 1'b1;
    end
    n_tests++;
    if (hit !== 1'b1) begin
      n_fail++; $display("FAIL t5_reach_bit16: got %b want 1", hit);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_tests++;
    if (bus.spi_control !== 32'h0 || bus.rsp_valid !== 4'b0 || bus.rsp_rdata !== 32'h0 ||
        bus.rsp_err !== 1'b0 || bus.req_ready !== 4'b0 || bus.spi_datain !== 32'h0) begin
      n_fail++; $display("FAIL t5_reset_outs: got ctrl=%h v=%b d=%h e=%b rdy=%b din=%h want 0",
                         bus.spi_control, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                         bus.req_ready, bus.spi_datain);
    end
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (bus.rsp_valid != 4'b0 || bus.spi_control[0]) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL t5_no_rsp: got %0d active cycles want 0", bad);
    end
    m_miso = 32'h31415926;
    bus.req_wdata[95:64] = 32'h27182818;
    bus.req_mode[5:4] = 2'b00;
    bus.req_valid = 4'b0100;
    wait_ready(20, rdy, n);
    bus.req_valid = '0;
    wait_rsp(500, v, d, e, c, n);
    n_tests++;
    if (rdy !== 4'b0100 || v !== 4'b0100 || d !== 32'h31415926 || e !== 1'b0 ||
        m_rx !== 32'h27182818) begin
      n_fail++; $display("FAIL t5_recover: got rdy=%b v=%b d=%h e=%b rx=%h want 0100 0100 31415926 0 27182818",
                         rdy, v, d, e, m_rx);
    end
  endtask

  task automatic test_fairness;
    logic [3:0] rdy, v;
    logic [31:0] d, c;
    logic e;
    int n;
    m_miso = 32'h77777777;
    bus.req_mode = '0;
    bus.req_wdata[127:96] = 32'h33333333;
    bus.req_wdata[31:0]   = 32'h11111111;
    bus.req_valid = 4'b1000;
    wait_ready(20, rdy, n);
    bus.req_valid = '0;
    wait_rsp(500, v, d, e, c, n);
    n_tests++;
    if (rdy !== 4'b1000 || v !== 4'b1000) begin
      n_fail++; $display("FAIL t6_prime: got rdy=%b v=%b want 1000 1000", rdy, v);
    end
    bus.req_valid = 4'b1001;
    wait_ready(20, rdy, n);
    n_tests++;
    if (rdy !== 4'b0001) begin
      n_fail++; $display("FAIL t6_grant1: got %b want 0001", rdy);
    end
    wait_ready(500, rdy, n);
    bus.req_valid = '0;
    n_tests++;
    if (rdy !== 4'b1000) begin
      n_fail++; $display("FAIL t6_grant2: got %b want 1000", rdy);
    end
    wait_rsp(500, v, d, e, c, n);
    n_tests++;
    if (v !== 4'b1000 || d !== 32'h77777777 || m_rx !== 32'h33333333) begin
      n_fail++; $display("FAIL t6_rsp: got v=%b d=%h rx=%h want 1000 77777777 33333333",
                         v, d, m_rx);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_mode  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_modes();
    test_timeout();
    test_reset_mid_busy();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
